// File: rtl/wb_slave_regfile_pkg.sv
// Shared types and constants for the Wishbone register-file slave.
package wb_pkg;

  // Slave transfer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } wb_slv_state_t;

  // Width of the wait-state counter (wait_cycles ranges over 0..15)
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic-cycle bus bundle between a master and the register-file slave.
//
// Handshake: a request is offered while wb_cyc && wb_stb are both high. The
// master must hold the request and its fields stable until it sees wb_ack high.
// wb_ack is high for exactly one cycle per accepted request. After the ack the
// master drops wb_stb/wb_cyc; the slave accepts no new request until it has
// sampled the request low at least once.
interface wb_slave_regfile_if #(
  parameter int bw_adr      = 8,
  parameter int bw_dat      = 8,
  parameter int granularity = 8
) ();
  localparam int bw_sel = bw_dat / granularity;

  logic [bw_adr-1:0] wb_adr;
  logic [bw_dat-1:0] wb_dat_w;
  logic [bw_sel-1:0] wb_sel;
  logic              wb_we;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_tagn_w;
  logic [bw_dat-1:0] wb_dat_r;
  logic              wb_ack;
  logic              wb_tagn_r;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb, wb_tagn_w,
    input  wb_dat_r, wb_ack, wb_tagn_r
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb, wb_tagn_w,
    output wb_dat_r, wb_ack, wb_tagn_r
  );
endinterface

// File: rtl/wb_slave_regfile_mem.sv
// Register storage: n_regs words with lane-masked synchronous write,
// synchronous read, and synchronous clear on reset.
module wb_regfile_mem #(
  parameter int n_regs      = 16,
  parameter int bw_dat      = 8,
  parameter int granularity = 8,
  parameter int bw_idx      = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_we,
  input  logic                            i_re,
  input  logic                            i_hit,
  input  logic [bw_idx-1:0]               i_idx,
  input  logic [bw_dat-1:0]               i_dat,
  input  logic [bw_dat/granularity-1:0]   i_sel,
  output logic [bw_dat-1:0]               o_dat
);
  localparam int bw_sel = bw_dat / granularity;

  logic [bw_dat-1:0] r_mem [n_regs];
  logic [bw_dat-1:0] r_dat;

  // Lane-masked write; only enabled lanes of the addressed word change
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < n_regs; i++) r_mem[i] <= '0;
    end else if (i_we && i_hit) begin
      for (int l = 0; l < bw_sel; l++) begin
        if (i_sel[l]) r_mem[i_idx][l*granularity +: granularity] <= i_dat[l*granularity +: granularity];
      end
    end
  end

  // Registered read; misses return zero, value holds until the next read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dat <= '0;
    end else if (i_re) begin
      r_dat <= i_hit ? r_mem[i_idx] : '0;
    end
  end

  assign o_dat = r_dat;
endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave fronting a register file: decodes the address,
// inserts wait_cycles wait states, then gives a single-cycle ack.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int bw_adr      = 8,
  parameter int bw_dat      = 8,
  parameter int granularity = 8,
  parameter int n_regs      = 16,
  parameter int wait_cycles = 0
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  wb_slave_regfile_if.slave bus,
  output wb_slv_state_t o_state
);
  localparam int bw_sel = bw_dat / granularity;
  localparam int bw_idx = (n_regs > 1) ? $clog2(n_regs) : 1;
  localparam logic [bw_adr:0] LIM = (bw_adr+1)'(n_regs);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (wait_cycles > 0) ? WAIT_CNT_W'(wait_cycles - 1) : '0;

  wb_slv_state_t         r_state;
  wb_slv_state_t         w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [bw_adr-1:0]     r_adr;
  logic [bw_dat-1:0]     r_dat_w;
  logic [bw_sel-1:0]     r_sel;
  logic                  r_we;
  logic                  r_ack;
  logic                  r_tagn;

  logic                  w_req;
  logic                  w_enter_ack;
  logic [bw_adr-1:0]     w_adr;
  logic [bw_dat-1:0]     w_dat_w;
  logic [bw_sel-1:0]     w_sel;
  logic                  w_we;
  logic                  w_hit;
  logic                  w_hit_r;
  logic [bw_dat-1:0]     w_mem_dat;
  logic                  w_unused_tagn;

  assign w_req         = bus.wb_cyc && bus.wb_stb;
  assign w_unused_tagn = bus.wb_tagn_w;

  // Next-state logic for the transfer FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = (wait_cycles > 0) ? WAIT : ACK;
      WAIT: begin
        if (!w_req)           w_next = IDLE;
        else if (r_cnt == '0) w_next = ACK;
      end
      ACK:  w_next = HOLD;
      HOLD: if (!w_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Wait-state counter: loaded on acceptance, counts down while waiting
  always_ff @(posedge wb_clk) begin
    if (wb_rst)                        r_cnt <= '0;
    else if (r_state == IDLE && w_req) r_cnt <= CNT_LOAD;
    else if (r_state == WAIT)          r_cnt <= r_cnt - 1'b1;
  end

  // Latch request fields when a request is accepted
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_adr   <= '0;
      r_dat_w <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_adr   <= bus.wb_adr;
      r_dat_w <= bus.wb_dat_w;
      r_sel   <= bus.wb_sel;
      r_we    <= bus.wb_we;
    end
  end

  // With no wait states ACK is entered straight from IDLE, before the latch
  // holds the fields, so the live bus values are used in that case.
  always_comb begin
    w_adr   = r_adr;
    w_dat_w = r_dat_w;
    w_sel   = r_sel;
    w_we    = r_we;
    if (r_state == IDLE) begin
      w_adr   = bus.wb_adr;
      w_dat_w = bus.wb_dat_w;
      w_sel   = bus.wb_sel;
      w_we    = bus.wb_we;
    end
  end

  assign w_enter_ack = (w_next == ACK) && (r_state != ACK);
  assign w_hit       = {1'b0, w_adr} < LIM;
  assign w_hit_r     = {1'b0, r_adr} < LIM;

  // Ack and tag follow the ACK state by one cycle; tag low only for misses
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_ack  <= 1'b0;
      r_tagn <= 1'b1;
    end else begin
      r_ack  <= (r_state == ACK);
      r_tagn <= !((r_state == ACK) && !w_hit_r);
    end
  end

  wb_regfile_mem #(
    .n_regs      (n_regs),
    .bw_dat      (bw_dat),
    .granularity (granularity),
    .bw_idx      (bw_idx)
  ) u_mem (
    .i_clk (wb_clk),
    .i_rst (wb_rst),
    .i_we  (w_enter_ack && w_we),
    .i_re  (w_enter_ack && !w_we),
    .i_hit (w_hit),
    .i_idx (w_adr[bw_idx-1:0]),
    .i_dat (w_dat_w),
    .i_sel (w_sel),
    .o_dat (w_mem_dat)
  );

  assign bus.wb_dat_r  = w_mem_dat;
  assign bus.wb_ack    = r_ack;
  assign bus.wb_tagn_r = r_tagn;
  assign o_state       = r_state;
endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: four instances (8-bit default, 32-bit with 0/3/5
// wait states) driven from shared stimulus, checked against a register model.
module tb_wb_slave_regfile;
  import wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [7:0]  t_adr = '0;
  logic [31:0] t_dat = '0;
  logic [3:0]  t_sel = '0;
  logic        t_we  = 1'b0;
  logic        t_stb = 1'b0;
  logic [3:0]  t_cyc = '0;

  logic [31:0] o_dat  [4];
  logic        o_ack  [4];
  logic        o_tagn [4];
  wb_slv_state_t st [4];

  wb_slave_regfile_if #(.bw_adr(8), .bw_dat(8),  .granularity(8)) if0 ();
  wb_slave_regfile_if #(.bw_adr(8), .bw_dat(32), .granularity(8)) if1 ();
  wb_slave_regfile_if #(.bw_adr(8), .bw_dat(32), .granularity(8)) if2 ();
  wb_slave_regfile_if #(.bw_adr(8), .bw_dat(32), .granularity(8)) if3 ();

  assign if0.wb_adr = t_adr; assign if0.wb_dat_w = t_dat[7:0]; assign if0.wb_sel = t_sel[0];
  assign if0.wb_we = t_we; assign if0.wb_cyc = t_cyc[0]; assign if0.wb_stb = t_stb; assign if0.wb_tagn_w = 1'b1;
  assign if1.wb_adr = t_adr; assign if1.wb_dat_w = t_dat; assign if1.wb_sel = t_sel;
  assign if1.wb_we = t_we; assign if1.wb_cyc = t_cyc[1]; assign if1.wb_stb = t_stb; assign if1.wb_tagn_w = 1'b1;
  assign if2.wb_adr = t_adr; assign if2.wb_dat_w = t_dat; assign if2.wb_sel = t_sel;
  assign if2.wb_we = t_we; assign if2.wb_cyc = t_cyc[2]; assign if2.wb_stb = t_stb; assign if2.wb_tagn_w = 1'b0;
  assign if3.wb_adr = t_adr; assign if3.wb_dat_w = t_dat; assign if3.wb_sel = t_sel;
  assign if3.wb_we = t_we; assign if3.wb_cyc = t_cyc[3]; assign if3.wb_stb = t_stb; assign if3.wb_tagn_w = 1'b0;

  assign o_dat[0] = {24'h0, if0.wb_dat_r}; assign o_ack[0] = if0.wb_ack; assign o_tagn[0] = if0.wb_tagn_r;
  assign o_dat[1] = if1.wb_dat_r;          assign o_ack[1] = if1.wb_ack; assign o_tagn[1] = if1.wb_tagn_r;
  assign o_dat[2] = if2.wb_dat_r;          assign o_ack[2] = if2.wb_ack; assign o_tagn[2] = if2.wb_tagn_r;
  assign o_dat[3] = if3.wb_dat_r;          assign o_ack[3] = if3.wb_ack; assign o_tagn[3] = if3.wb_tagn_r;

  wb_slave_regfile u_d0 (.wb_clk(clk), .wb_rst(rst), .bus(if0), .o_state(st[0]));
  wb_slave_regfile #(.bw_dat(32)) u_d1 (.wb_clk(clk), .wb_rst(rst), .bus(if1), .o_state(st[1]));
  wb_slave_regfile #(.bw_dat(32), .wait_cycles(3)) u_d2 (.wb_clk(clk), .wb_rst(rst), .bus(if2), .o_state(st[2]));
  wb_slave_regfile #(.bw_dat(32), .wait_cycles(5)) u_d3 (.wb_clk(clk), .wb_rst(rst), .bus(if3), .o_state(st[3]));

  // ---------------- reference model / scoreboard ----------------
  int waits [4] = '{0, 0, 3, 5};
  int lanes [4] = '{1, 4, 4, 4};
  logic [31:0] mdl [4][16];
  logic [31:0] last_rd [4];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      last_rd[k] = '0;
      for (int a = 0; a < 16; a++) mdl[k][a] = '0;
    end
  endtask

  // ---------------- driver ----------------
  // One full transfer on instance k; the master keeps the request up for
  // hold_extra cycles beyond the ack, then releases it.
  task automatic xfer(input int k, input logic we, input logic [7:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int hold_extra, output logic [31:0] rd_obs);
    int w;
    logic [31:0] e;
    w = waits[k];
    rd_obs = 'x;
    @(negedge clk);
    t_adr = adr; t_dat = dat; t_sel = sel; t_we = we;
    t_cyc[k] = 1'b1; t_stb = 1'b1;
    @(posedge clk);
    if (we) begin
      if (adr < 16) begin
        for (int b = 0; b < lanes[k]; b++)
          if (sel[b]) mdl[k][adr][8*b +: 8] = dat[8*b +: 8];
      end
    end else begin
      last_rd[k] = (adr < 16) ? mdl[k][adr] : 32'h0;
    end
    exp_q.push_back(last_rd[k]);
    for (int c = 1; c <= w + 3 + hold_extra; c++) begin
      @(posedge clk); #1;
      chk("ack", {31'h0, o_ack[k]}, {31'h0, c == w + 1});
      if (c == w + 1) begin
        chk("tagn_at_ack", {31'h0, o_tagn[k]}, {31'h0, adr < 16});
        e = exp_q.pop_front();
        chk("dat_r", o_dat[k], e);
        rd_obs = o_dat[k];
      end else begin
        chk("tagn_idle", {31'h0, o_tagn[k]}, 32'h1);
      end
      if (c == w + 1 + hold_extra) begin
        t_cyc[k] = 1'b0; t_stb = 1'b0;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [7:0]  ra;
    int          rk;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_ack", {31'h0, o_ack[k]}, 32'h0);
      chk("rst_dat", o_dat[k], 32'h0);
      chk("rst_tagn", {31'h0, o_tagn[k]}, 32'h1);
    end
    @(negedge clk); rst = 1'b0;

    // Default 8-bit instance: write then read
    xfer(0, 1'b1, 8'd3, 32'hA5, 4'h1, 0, rd);
    xfer(0, 1'b0, 8'd3, 32'h0, 4'h1, 0, rd);
    chk("d0_rd_a5", rd, 32'hA5);

    // 32-bit lane merge
    xfer(1, 1'b1, 8'd1, 32'hFFFFFFFF, 4'hF, 0, rd);
    xfer(1, 1'b1, 8'd1, 32'h12345678, 4'h5, 0, rd);
    xfer(1, 1'b0, 8'd1, 32'h0, 4'h0, 0, rd);
    chk("d1_lane_merge", rd, 32'hFF34FF78);

    // Three wait states, master holds stb two extra cycles
    xfer(2, 1'b0, 8'd0, 32'h0, 4'hF, 2, rd);

    // Out of range write/read, then the whole bank is unchanged
    xfer(1, 1'b1, 8'd20, 32'h55, 4'hF, 0, rd);
    xfer(1, 1'b0, 8'd20, 32'h0, 4'hF, 0, rd);
    chk("d1_oor_rd", rd, 32'h0);
    for (int a = 0; a < 16; a++) xfer(1, 1'b0, 8'(a), 32'h0, 4'hF, 0, rd);

    // Abort during wait states: no ack, no write
    @(negedge clk);
    t_adr = 8'd2; t_dat = 32'h77; t_sel = 4'hF; t_we = 1'b1;
    t_cyc[3] = 1'b1; t_stb = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_ack_pre", {31'h0, o_ack[3]}, 32'h0);
    end
    t_cyc[3] = 1'b0; t_stb = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_ack_post", {31'h0, o_ack[3]}, 32'h0);
    end
    xfer(3, 1'b0, 8'd2, 32'h0, 4'hF, 0, rd);
    chk("abort_reg2", rd, 32'h0);

    // Random traffic across all instances
    for (int n = 0; n < 60; n++) begin
      rk = $urandom_range(3, 0);
      ra = 8'($urandom_range(19, 0));
      xfer(rk, 1'($urandom_range(1, 0)), ra, $urandom, 4'($urandom_range(15, 0)),
           $urandom_range(2, 0), rd);
    end

    // Reset while a write sits in wait states
    @(negedge clk);
    t_adr = 8'd5; t_dat = 32'hDEADBEEF; t_sel = 4'hF; t_we = 1'b1;
    t_cyc[2] = 1'b1; t_stb = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; t_cyc[2] = 1'b0; t_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (6) begin
      @(posedge clk); #1;
      chk("rstmid_ack", {31'h0, o_ack[2]}, 32'h0);
    end
    for (int k = 0; k < 4; k++) chk("rstmid_dat", o_dat[k], 32'h0);
    for (int a = 0; a < 16; a++) xfer(2, 1'b0, 8'(a), 32'h0, 4'hF, 0, rd);
    for (int a = 0; a < 16; a += 5) xfer(1, 1'b0, 8'(a), 32'h0, 4'hF, 0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
